// File: rtl/wifi_tx_puncturer.sv
// rtl/wifi_tx_puncturer.sv - multi-rate 802.11a convolutional-code puncturer with frame drain
// Optional 5/6 rate: define WIFI_PUNCT_RATE56_EN (otherwise rate_sel=11 acts as 3/4).
module wifi_tx_puncturer #(
    parameter int CNT_W    = 3,
    parameter int BITCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          rate_sel,
    input  logic                valid_in,
    input  logic [1:0]          data_in,
    output logic                ready_in,
    output logic                valid_out,
    output logic                data_out,
    output logic                finished,
    output logic [BITCNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         rate_q;
    logic [1:0]         hold;       // [1]=A, [0]=B of the pair being serialised
    logic [1:0]         mask;       // {keepA, keepB} still to be emitted
    logic [1:0]         keep;
    logic [CNT_W-1:0]   pat_cnt;
    logic [CNT_W-1:0]   period_m1;
    logic               transfer;
    logic               frame_start;

    // Pattern period is fixed by the rate latched at frame start.
    always_comb begin
        period_m1 = '0;
        case (rate_q)
            2'b00:   period_m1 = CNT_W'(0);
            2'b01:   period_m1 = CNT_W'(1);
            2'b10:   period_m1 = CNT_W'(2);
`ifdef WIFI_PUNCT_RATE56_EN
            default: period_m1 = CNT_W'(4);
`else
            default: period_m1 = CNT_W'(2);
`endif
        endcase
    end

    // Every supported pattern keeps AB at position 0, then alternates A (odd) / B (even).
    always_comb begin
        keep = 2'b11;
        if (pat_cnt != '0)
            keep = pat_cnt[0] ? 2'b10 : 2'b01;
    end

    // A new pair fits once at most one bit of the held pair remains, so pop and load can share an edge.
    assign ready_in    = (state == RUN) && enable && (mask != 2'b11);
    assign transfer    = valid_in && ready_in;
    assign frame_start = (state == IDLE) && enable;

    // Frame sequencing: run while enabled, then drain the hold register before signalling done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)        state_nxt = RUN;
            RUN:     if (!enable)       state_nxt = DRAIN;
            DRAIN:   if (mask == 2'b00) state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State, rate and pattern position registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rate_q  <= 2'b00;
            pat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (frame_start) begin
                rate_q  <= rate_sel;
                pat_cnt <= '0;
            end else if (transfer) begin
                pat_cnt <= (pat_cnt >= period_m1) ? '0 : pat_cnt + CNT_W'(1);
            end
        end
    end

    // Hold register and serialiser: emit A before B, load a new pair when accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= 2'b00;
            mask      <= 2'b00;
            valid_out <= 1'b0;
            data_out  <= 1'b0;
        end else begin
            valid_out <= (mask != 2'b00);
            if (mask != 2'b00)
                data_out <= mask[1] ? hold[1] : hold[0];
            if (transfer) begin
                hold <= data_in;
                mask <= keep;
            end else if (mask[1]) begin
                mask <= {1'b0, mask[0]};
            end else begin
                mask <= 2'b00;
            end
        end
    end

    // Frame bit counter (saturating, kept after DONE) and the one-cycle finished pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_count <= '0;
            finished  <= 1'b0;
        end else begin
            finished <= (state_nxt == DONE);
            if (frame_start)
                bit_count <= '0;
            else if ((mask != 2'b00) && (bit_count != '1))
                bit_count <= bit_count + BITCNT_W'(1);
        end
    end

endmodule
